// File: rtl/program_executor.sv
// program_executor: execute/control stage for the 3-bit-instruction machine.
// Owns the instruction pointer, drives fetch (instr_ptr/halt_if), executes the
// registered opcode/operand against A/B/C and streams 3-bit values out over
// valid/ready. Optional retired-instruction watchdog: define
// PROGRAM_EXECUTOR_WATCHDOG_EN (limit set by MAX_STEPS).
module program_executor #(
  parameter int unsigned REG_W     = 32,
  parameter int unsigned PROG_LEN  = 16,
  parameter int unsigned MAX_STEPS = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [REG_W-1:0] a_init,
  input  logic [REG_W-1:0] b_init,
  input  logic [REG_W-1:0] c_init,
  input  logic [2:0]       opcode,
  input  logic [2:0]       operand,
  output logic [3:0]       instr_ptr,
  output logic             halt_if,
  output logic [2:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             done,
  output logic             err,
  output logic [REG_W-1:0] reg_a,
  output logic [REG_W-1:0] reg_b,
  output logic [REG_W-1:0] reg_c
);

  localparam logic [4:0] PROG_END = 5'(PROG_LEN);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_t;

  state_t           state, state_nx;
  logic [4:0]       ip, ip_nx, ip_seq;
  logic [REG_W-1:0] a_q, b_q, c_q, a_nx, b_nx, c_nx;
  logic             err_q, err_nx;
  logic [REG_W-1:0] combo;
  logic             uses_combo, combo_bad, stall, load;

`ifdef PROGRAM_EXECUTOR_WATCHDOG_EN
  localparam int unsigned        STEP_W    = $clog2(MAX_STEPS + 1);
  localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(MAX_STEPS - 1);
  logic [STEP_W-1:0] steps;
`endif

  assign ip_seq     = ip + 5'd2;
  assign uses_combo = opcode inside {3'd0, 3'd2, 3'd5, 3'd6, 3'd7};
  assign combo_bad  = uses_combo && (operand == 3'd7);
  assign stall      = (state == S_EXEC) && (opcode == 3'd5) && !combo_bad && !out_ready;
  assign load       = start && ((state == S_IDLE) || (state == S_DONE));

  // Combo operand decode: literals 0..3, registers for 4..6 (7 flagged via combo_bad)
  always_comb begin
    combo = '0;
    case (operand)
      3'd4:    combo = a_q;
      3'd5:    combo = b_q;
      3'd6:    combo = c_q;
      default: combo = REG_W'(operand);
    endcase
  end

  // Next-state, execute and fetch-control decode
  always_comb begin
    state_nx  = state;
    ip_nx     = ip;
    a_nx      = a_q;
    b_nx      = b_q;
    c_nx      = c_q;
    err_nx    = err_q;
    halt_if   = 1'b1;
    out_valid = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_nx     = a_init;
          b_nx     = b_init;
          c_nx     = c_init;
          ip_nx    = '0;
          err_nx   = 1'b0;
          state_nx = S_FETCH;
        end
      end
      S_FETCH: begin
        halt_if  = 1'b0;
        state_nx = S_EXEC;
      end
      S_EXEC: begin
        if (combo_bad) begin
          err_nx   = 1'b1;
          state_nx = S_DONE;
        end else if (stall) begin
          out_valid = 1'b1;
        end else begin
          state_nx = S_FETCH;
          ip_nx    = ip_seq;
          // Right shifts by >= REG_W already yield zero in SV semantics.
          case (opcode)
            3'd0: a_nx = a_q >> combo;
            3'd1: b_nx = b_q ^ REG_W'(operand);
            3'd2: b_nx = REG_W'(combo[2:0]);
            3'd3: begin
              if (a_q != '0) begin
                if (operand[0]) begin
                  err_nx   = 1'b1;
                  state_nx = S_DONE;
                  ip_nx    = ip;
                end else begin
                  ip_nx = {2'b00, operand};
                end
              end
            end
            3'd4: b_nx = b_q ^ c_q;
            3'd5: out_valid = 1'b1;
            3'd6: b_nx = a_q >> combo;
            3'd7: c_nx = a_q >> combo;
          endcase
          if ((state_nx == S_FETCH) && (ip_nx >= PROG_END)) state_nx = S_DONE;
`ifdef PROGRAM_EXECUTOR_WATCHDOG_EN
          if (steps == STEP_LAST) begin
            err_nx   = 1'b1;
            state_nx = S_DONE;
          end
`endif
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Architectural state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ip    <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      ip    <= ip_nx;
      a_q   <= a_nx;
      b_q   <= b_nx;
      c_q   <= c_nx;
      err_q <= err_nx;
    end
  end

`ifdef PROGRAM_EXECUTOR_WATCHDOG_EN
  // Retired-instruction counter: cleared on start, counts every EXEC exit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          steps <= '0;
    else if (load)                       steps <= '0;
    else if ((state == S_EXEC) && !stall) steps <= steps + STEP_W'(1);
  end
`endif

  assign out_data  = out_valid ? combo[2:0] : 3'd0;
  assign instr_ptr = ip[3:0];
  assign done      = (state == S_DONE);
  assign err       = err_q;
  assign reg_a     = a_q;
  assign reg_b     = b_q;
  assign reg_c     = c_q;

endmodule

// File: tb/tb_program_executor.sv
// Directed self-checking bench for program_executor. Two instances share a
// behavioural fetch stage model: u_dut (PROG_LEN=6) and u_dut2 (PROG_LEN=2,
// MAX_STEPS=8).
module tb_program_executor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, start2 = 1'b0, out_ready = 1'b1;
  logic [31:0] a_init = '0, b_init = '0, c_init = '0;
  logic [2:0]  prog [16];

  logic [2:0]  opcode, operand, out_data, opcode2, operand2, out_data2;
  logic [3:0]  instr_ptr, instr_ptr2;
  logic        halt_if, out_valid, done, err, halt_if2, out_valid2, done2, err2;
  logic [31:0] reg_a, reg_b, reg_c, reg_a2, reg_b2, reg_c2;

  logic [2:0]  outq [$];
  bit          seen2;
  int          total = 0, bad = 0;
  logic [2:0]  exp1 [10];

  always #5 clk = ~clk;

  program_executor #(.REG_W(32), .PROG_LEN(6), .MAX_STEPS(1024)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_init(a_init), .b_init(b_init), .c_init(c_init),
    .opcode(opcode), .operand(operand), .instr_ptr(instr_ptr), .halt_if(halt_if),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .done(done), .err(err),
    .reg_a(reg_a), .reg_b(reg_b), .reg_c(reg_c)
  );

  program_executor #(.REG_W(32), .PROG_LEN(2), .MAX_STEPS(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a_init(a_init), .b_init(b_init), .c_init(c_init),
    .opcode(opcode2), .operand(operand2), .instr_ptr(instr_ptr2), .halt_if(halt_if2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(1'b1), .done(done2), .err(err2),
    .reg_a(reg_a2), .reg_b(reg_b2), .reg_c(reg_c2)
  );

  // Fetch stage model: latch the word pair at instr_ptr whenever not halted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode <= '0; operand <= '0; opcode2 <= '0; operand2 <= '0;
    end else begin
      if (!halt_if) begin
        opcode  <= prog[instr_ptr];
        operand <= prog[instr_ptr + 4'd1];
      end
      if (!halt_if2) begin
        opcode2  <= prog[instr_ptr2];
        operand2 <= prog[instr_ptr2 + 4'd1];
      end
    end
  end

  // Output monitor: one transfer per cycle with valid and ready high
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) outq.push_back(out_data);
    if (out_valid2) seen2 = 1'b1;
  end

  task automatic set_prog(input logic [17:0] w);
    for (int i = 0; i < 16; i++) prog[i] = 3'd0;
    for (int i = 0; i < 6; i++) prog[i] = w[17 - 3*i -: 3];
  endtask

  task automatic pulse_start(input bit second);
    @(posedge clk); #1;
    if (second) start2 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start2 = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++; if ({done, err, out_valid, halt_if} !== 4'b0001) begin bad++;
      $display("FAIL reset_ctl: got %b want 0001", {done, err, out_valid, halt_if}); end
    total++; if ({instr_ptr, out_data} !== 7'd0) begin bad++;
      $display("FAIL reset_ip_data: got ip=%0d data=%0d want 0/0", instr_ptr, out_data); end
    total++; if ((reg_a | reg_b | reg_c) !== 32'd0) begin bad++;
      $display("FAIL reset_regs: got %0d %0d %0d want 0", reg_a, reg_b, reg_c); end
    @(posedge clk); #2 rst_n = 1'b1;
  endtask

  task automatic test_program;
    bit ok;
    exp1 = '{3'd4, 3'd6, 3'd3, 3'd5, 3'd6, 3'd3, 3'd5, 3'd2, 3'd1, 3'd0};
    set_prog({3'd0, 3'd1, 3'd5, 3'd4, 3'd3, 3'd0});
    a_init = 32'd729; b_init = '0; c_init = '0; out_ready = 1'b1;
    outq.delete();
    pulse_start(1'b0);
    wait_done(300, ok);
    total++; if (!ok) begin bad++; $display("FAIL prog_done: got timeout want done"); end
    total++; if (outq.size() != 10) begin bad++;
      $display("FAIL prog_count: got %0d want 10", outq.size()); end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (i >= outq.size()) begin bad++; $display("FAIL prog_out%0d: got none want %0d", i, exp1[i]); end
      else if (outq[i] !== exp1[i]) begin bad++;
        $display("FAIL prog_out%0d: got %0d want %0d", i, outq[i], exp1[i]); end
    end
    total++; if ({err, reg_a} !== 33'd0) begin bad++;
      $display("FAIL prog_final: got err=%0b A=%0d want 0/0", err, reg_a); end
  endtask

  task automatic test_bst;
    set_prog({3'd2, 3'd6, 12'd0});
    a_init = '0; b_init = 32'h55; c_init = 32'd9; seen2 = 1'b0;
    pulse_start(1'b1);
    @(posedge clk); #1;
    total++; if (done2 !== 1'b0) begin bad++; $display("FAIL bst_early: got done=%0b want 0", done2); end
    @(posedge clk); #1;
    total++; if ({done2, err2} !== 2'b10) begin bad++;
      $display("FAIL bst_done: got %b want 10", {done2, err2}); end
    total++; if (reg_b2 !== 32'd1) begin bad++; $display("FAIL bst_b: got %0d want 1", reg_b2); end
    total++; if (seen2 !== 1'b0) begin bad++; $display("FAIL bst_novalid: got %0b want 0", seen2); end
  endtask

  task automatic test_alu;
    bit ok;
    set_prog({3'd6, 3'd2, 3'd7, 3'd1, 3'd4, 3'd0});
    a_init = 32'd200; b_init = 32'd3; c_init = 32'd5;
    pulse_start(1'b0);
    wait_done(50, ok);
    total++; if (!ok) begin bad++; $display("FAIL alu_done: got timeout want done"); end
    total++; if ({reg_a, reg_b, reg_c} !== {32'd200, 32'd86, 32'd100}) begin bad++;
      $display("FAIL alu_regs: got %0d %0d %0d want 200 86 100", reg_a, reg_b, reg_c); end
  endtask

  task automatic test_shift_boundary;
    bit ok;
    set_prog({3'd0, 3'd5, 3'd1, 3'd0, 3'd1, 3'd0});
    a_init = 32'hFFFF_FFFF; b_init = 32'd40; c_init = '0;
    pulse_start(1'b0);
    wait_done(50, ok);
    total++; if (!ok || reg_a !== 32'd0 || err !== 1'b0) begin bad++;
      $display("FAIL shift_big: got A=%0d err=%0b want 0/0", reg_a, err); end
    set_prog({3'd0, 3'd4, 3'd1, 3'd0, 3'd1, 3'd0});
    a_init = 32'd32;
    pulse_start(1'b0);
    wait_done(50, ok);
    total++; if (!ok || reg_a !== 32'd0) begin bad++;
      $display("FAIL shift_32: got A=%0d want 0", reg_a); end
  endtask

  task automatic test_jump_end;
    bit ok;
    set_prog({3'd3, 3'd6, 3'd1, 3'd7, 3'd1, 3'd7});
    a_init = 32'd1; b_init = '0; c_init = '0;
    pulse_start(1'b0);
    wait_done(50, ok);
    total++; if (!ok || {err, reg_b} !== 33'd0) begin bad++;
      $display("FAIL jump_end: got err=%0b B=%0d want 0/0", err, reg_b); end
  endtask

  task automatic test_stall;
    bit ok;
    set_prog({3'd5, 3'd0, 3'd5, 3'd1, 3'd1, 3'd0});
    a_init = '0; b_init = '0; c_init = '0; out_ready = 1'b0;
    outq.delete();
    pulse_start(1'b0);
    wait_valid(10, ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_valid: got timeout want valid"); end
    for (int k = 0; k < 5; k++) begin
      total++; if ({out_valid, out_data, halt_if, instr_ptr} !== {1'b1, 3'd0, 1'b1, 4'd0}) begin bad++;
        $display("FAIL stall_hold%0d: got v=%0b d=%0d h=%0b ip=%0d want 1 0 1 0",
                 k, out_valid, out_data, halt_if, instr_ptr); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_done(50, ok);
    total++; if (!ok || outq.size() != 2) begin bad++;
      $display("FAIL stall_count: got %0d want 2", outq.size()); end
    else begin
      total++; if ({outq[0], outq[1]} !== {3'd0, 3'd1}) begin bad++;
        $display("FAIL stall_seq: got %0d,%0d want 0,1", outq[0], outq[1]); end
    end
  endtask

  task automatic test_errors;
    bit ok;
    set_prog({3'd0, 3'd7, 3'd1, 3'd0, 3'd1, 3'd0});
    a_init = 32'd5; b_init = '0; c_init = '0;
    pulse_start(1'b0);
    wait_done(20, ok);
    total++; if (!ok || err !== 1'b1 || reg_a !== 32'd5) begin bad++;
      $display("FAIL combo7: got err=%0b A=%0d want 1/5", err, reg_a); end
    set_prog({3'd3, 3'd1, 3'd1, 3'd7, 3'd1, 3'd7});
    pulse_start(1'b0);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear: got %0b want 0", err); end
    wait_done(20, ok);
    total++; if (!ok || err !== 1'b1 || reg_b !== 32'd0) begin bad++;
      $display("FAIL odd_jump: got err=%0b B=%0d want 1/0", err, reg_b); end
  endtask

  task automatic test_reset_mid_stall;
    bit ok;
    set_prog({3'd5, 3'd0, 3'd5, 3'd1, 3'd1, 3'd0});
    a_init = 32'd7; b_init = 32'd3; c_init = 32'd2; out_ready = 1'b0;
    pulse_start(1'b0);
    wait_valid(10, ok);
    total++; if (!ok) begin bad++; $display("FAIL rst_stall_valid: got timeout want valid"); end
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    total++; if ({done, err, out_valid, halt_if, instr_ptr, out_data} !== {4'b0001, 4'd0, 3'd0}) begin bad++;
      $display("FAIL rst_mid_ctl: got d=%0b e=%0b v=%0b h=%0b ip=%0d data=%0d want 0 0 0 1 0 0",
               done, err, out_valid, halt_if, instr_ptr, out_data); end
    total++; if ((reg_a | reg_b | reg_c) !== 32'd0) begin bad++;
      $display("FAIL rst_mid_regs: got %0d %0d %0d want 0", reg_a, reg_b, reg_c); end
    #4 rst_n = 1'b1;
    out_ready = 1'b1;
    outq.delete();
    pulse_start(1'b0);
    wait_done(50, ok);
    total++; if (!ok || outq.size() != 2 || err !== 1'b0) begin bad++;
      $display("FAIL rerun: got n=%0d err=%0b want 2/0", outq.size(), err); end
    else begin
      total++; if ({outq[0], outq[1]} !== {3'd0, 3'd1}) begin bad++;
        $display("FAIL rerun_seq: got %0d,%0d want 0,1", outq[0], outq[1]); end
    end
  endtask

  task automatic test_watchdog;
    set_prog({3'd3, 3'd0, 12'd0});
    a_init = 32'd1; b_init = '0; c_init = '0;
    pulse_start(1'b1);
`ifdef PROGRAM_EXECUTOR_WATCHDOG_EN
    repeat (15) begin @(posedge clk); #1; end
    total++; if (done2 !== 1'b0) begin bad++; $display("FAIL wd_early: got done=%0b want 0", done2); end
    @(posedge clk); #1;
    total++; if ({done2, err2} !== 2'b11) begin bad++;
      $display("FAIL wd_trip: got %b want 11", {done2, err2}); end
`else
    repeat (100) @(negedge clk);
    total++; if ({done2, err2} !== 2'b00) begin bad++;
      $display("FAIL wd_absent: got %b want 00", {done2, err2}); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 16; i++) prog[i] = 3'd0;
    test_reset;
    test_program;
    test_bst;
    test_alu;
    test_shift_boundary;
    test_jump_end;
    test_stall;
    test_errors;
    test_reset_mid_stall;
    test_watchdog;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
